// File: rtl/sop_fsm_fabric.sv
// sop_fsm_fabric: runtime-reconfigurable sum-of-products next-state fabric.
//
// Each of the N_ST state bits has its own next-state function built from
// N_PT product elements, each selecting N_LIT literals out of a shared pool
// (inputs, state bits, their complements, constant 1, constant 0). The
// configuration word is shifted in serially into a shadow register, parity
// checked on commit and copied into the active register, which is then
// parity-monitored every cycle.
//
// Build option: define SOPFSM_CFG_TMR_EN to hold the active configuration in
// three voted, self-scrubbing copies instead of a single parity-checked copy.
module sop_fsm_fabric #(
  parameter int N_IN  = 3,
  parameter int N_ST  = 2,
  parameter int N_PT  = 3,
  parameter int N_LIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_i,
  input  logic            step,
  input  logic            cfg_shift,
  input  logic            cfg_din,
  input  logic            cfg_commit,
  input  logic            cfg_par,
  output logic [N_ST-1:0] state_q,
  output logic            cfg_valid,
  output logic            cfg_ack,
  output logic            cfg_nack,
  output logic            cfg_err
);

  // Literal pool geometry and configuration word layout.
  localparam int NP   = N_IN + N_ST;        // true literals
  localparam int P    = 2 * NP + 1;         // true, complemented, constant 1
  localparam int SW   = $clog2(P);          // literal selector width
  localparam int PW   = 2 ** SW;            // selector range; codes >= P read 0
  localparam int EW   = N_LIT * SW + 2;     // one element: mode + selectors
  localparam int OW   = N_PT * EW + 1;      // one state bit: combine + elements
  localparam int CW   = N_ST * OW;          // whole configuration word
  localparam int CNTW = $clog2(CW + 1);

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_SHIFT = 2'd1,
    LD_FULL  = 2'd2,
    LD_OVF   = 2'd3
  } loader_e;

  loader_e            ld_q, ld_next;
  logic [CNTW-1:0]    cnt_q, cnt_next;
  logic               shift_en;
  logic               accept;
  logic [CW-1:0]      shadow_q;
  logic               par_q;
  logic [CW-1:0]      cfg_w;
  logic               par_bad;
  logic               err_set;
  logic               step_ok;
  logic [PW-1:0]      pool;
  logic [N_ST-1:0]    ns;
  logic [N_ST-1:0][N_PT-1:0] elem_val;

  // Evaluate one product element: mode selects const 0, AND, OR or passthrough.
  function automatic logic elem_eval(input logic [EW-1:0] el,
                                     input logic [PW-1:0] lits);
    logic          all_one;
    logic          any_one;
    logic [SW-1:0] sel;
    all_one = 1'b1;
    any_one = 1'b0;
    for (int k = 0; k < N_LIT; k++) begin
      sel     = el[(N_LIT-1-k)*SW +: SW];
      all_one = all_one & lits[sel];
      any_one = any_one | lits[sel];
    end
    case (el[EW-1 -: 2])
      2'b00:   elem_eval = 1'b0;
      2'b01:   elem_eval = all_one;
      2'b10:   elem_eval = any_one;
      default: elem_eval = lits[el[(N_LIT-1)*SW +: SW]];
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Active configuration storage
  // ---------------------------------------------------------------------
`ifdef SOPFSM_CFG_TMR_EN
  logic [CW-1:0] act_q [3];
  logic          copy_bad;

  // Bitwise majority of the three copies drives the logic and the scrub.
  always_comb begin
    cfg_w    = (act_q[0] & act_q[1]) | (act_q[1] & act_q[2]) | (act_q[0] & act_q[2]);
    copy_bad = (act_q[0] != act_q[1]) || (act_q[1] != act_q[2]);
    par_bad  = (^cfg_w) != par_q;
    err_set  = copy_bad || par_bad;
    // A single-copy upset is outvoted, so only a voted parity fault stops stepping.
    step_ok  = step && cfg_valid && !par_bad;
  end

  // Load all copies on commit; otherwise rewrite every copy with the vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) act_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) act_q[i] <= accept ? shadow_q : cfg_w;
    end
  end
`else
  logic [CW-1:0] active_q;

  // Single copy; parity mismatch both flags and immediately blocks stepping.
  always_comb begin
    cfg_w   = active_q;
    par_bad = (^active_q) != par_q;
    err_set = par_bad;
    step_ok = step && cfg_valid && !cfg_err && !par_bad;
  end

  // Active word changes only on an accepted commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the configuration words are reset like any other register, so
      // the fabric never evaluates an unknown function after power-up.
      active_q <= '0;
    end else if (accept) begin
      active_q <= shadow_q;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Next-state fabric
  // ---------------------------------------------------------------------

  // Literal pool: true literals, their complements, constant 1, then zeros.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    pool              = '0;
    pool[NP-1:0]      = {state_q, in_i};
    pool[2*NP-1:NP]   = ~{state_q, in_i};
    pool[2*NP]        = 1'b1;
  end

  for (genvar j = 0; j < N_ST; j++) begin : g_bit
    for (genvar e = 0; e < N_PT; e++) begin : g_elem
      // Element 0 sits just below the combine bit; later elements go lower.
      localparam int LO = j * OW + (N_PT - 1 - e) * EW;
      assign elem_val[j][e] = elem_eval(cfg_w[LO +: EW], pool);
    end
    // Combine bit at the top of the slice picks OR (1) or AND (0) of elements.
    assign ns[j] = cfg_w[j*OW + OW - 1] ? (|elem_val[j]) : (&elem_val[j]);
  end

  // ---------------------------------------------------------------------
  // Serial loader
  // ---------------------------------------------------------------------

  // Loader next state: commit always wins and returns to IDLE.
  always_comb begin
    ld_next  = ld_q;
    cnt_next = cnt_q;
    shift_en = 1'b0;
    accept   = 1'b0;
    if (cfg_commit) begin
      ld_next  = LD_IDLE;
      cnt_next = '0;
      accept   = (ld_q == LD_FULL) && ((^shadow_q) == cfg_par);
    end else if (cfg_shift) begin
      case (ld_q)
        LD_IDLE, LD_SHIFT: begin
          shift_en = 1'b1;
          cnt_next = cnt_q + 1'b1;
          ld_next  = (cnt_q == CNTW'(CW - 1)) ? LD_FULL : LD_SHIFT;
        end
        LD_FULL: ld_next = LD_OVF;
        default: ld_next = LD_OVF;   // overflowed: count frozen, bits ignored
      endcase
    end
  end

  // Loader state and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      ld_q  <= LD_IDLE;
      cnt_q <= '0;
    end else begin
      ld_q  <= ld_next;
      cnt_q <= cnt_next;
    end
  end

  // Shadow register: MSB of the word enters first and ends up on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (shift_en) begin
      shadow_q <= {shadow_q[CW-2:0], cfg_din};
    end
  end

  // Commit status, stored parity and the sticky integrity flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q     <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_nack  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ack  <= cfg_commit && accept;
      cfg_nack <= cfg_commit && !accept;
      if (accept) begin
        par_q     <= cfg_par;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else if (err_set) begin
        cfg_err   <= 1'b1;
      end
    end
  end

  // State register advances on step while the active configuration is usable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (step_ok) begin
      state_q <= ns;
    end
  end

endmodule

// File: tb/tb_sop_fsm_fabric.sv
// tb_sop_fsm_fabric: directed bench for sop_fsm_fabric with a behavioural
// model (field decoding + literal semantics) checked every cycle, plus
// hand-computed literal expectations. Honours SOPFSM_CFG_TMR_EN.
module tb_sop_fsm_fabric;

  localparam int N_IN  = 3;
  localparam int N_ST  = 2;
  localparam int N_PT  = 3;
  localparam int N_LIT = 4;
  localparam int NP    = N_IN + N_ST;
  localparam int SW    = 4;
  localparam int EW    = N_LIT * SW + 2;
  localparam int OW    = N_PT * EW + 1;
  localparam int CW    = N_ST * OW;

  typedef logic [CW-1:0] word_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_IN-1:0] in_i = '0;
  logic            step = 1'b0;
  logic            cfg_shift = 1'b0;
  logic            cfg_din = 1'b0;
  logic            cfg_commit = 1'b0;
  logic            cfg_par = 1'b0;
  logic [N_ST-1:0] state_q;
  logic            cfg_valid;
  logic            cfg_ack;
  logic            cfg_nack;
  logic            cfg_err;

  int total = 0;
  int bad   = 0;

  sop_fsm_fabric #(.N_IN(N_IN), .N_ST(N_ST), .N_PT(N_PT), .N_LIT(N_LIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_i       (in_i),
    .step       (step),
    .cfg_shift  (cfg_shift),
    .cfg_din    (cfg_din),
    .cfg_commit (cfg_commit),
    .cfg_par    (cfg_par),
    .state_q    (state_q),
    .cfg_valid  (cfg_valid),
    .cfg_ack    (cfg_ack),
    .cfg_nack   (cfg_nack),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- configuration word helpers ----------------
  function automatic int elem_lo(input int j, input int e);
    return j * OW + (N_PT - 1 - e) * EW;
  endfunction

  function automatic word_t put(input word_t w, input int lo, input int val);
    return w | (word_t'(val) << lo);
  endfunction

  function automatic int field(input word_t w, input int lo, input int width);
    word_t t;
    t = w >> lo;
    return int'(t[3:0]) & ((1 << width) - 1);
  endfunction

  function automatic word_t set_elem(input word_t w, input int j, input int e, input int mode,
                                     input int l0, input int l1, input int l2, input int l3);
    word_t r;
    int    lo;
    lo = elem_lo(j, e);
    r  = put(w, lo + EW - 2, mode);
    r  = put(r, lo + 3 * SW, l0);
    r  = put(r, lo + 2 * SW, l1);
    r  = put(r, lo + 1 * SW, l2);
    r  = put(r, lo, l3);
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic lit_val(input int code, input logic [N_IN-1:0] x, input logic [N_ST-1:0] s);
    logic [31:0] v;
    int          c;
    v = {25'd0, s, x};
    if (code < NP) return v[code[4:0]];
    if (code < 2 * NP) begin
      c = code - NP;
      return ~v[c[4:0]];
    end
    if (code == 2 * NP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N_ST-1:0] model_ns(input word_t w, input logic [N_IN-1:0] x,
                                               input logic [N_ST-1:0] s);
    logic [N_ST-1:0] r;
    r = '0;
    for (int j = 0; j < N_ST; j++) begin
      int n_true;
      n_true = 0;
      for (int e = 0; e < N_PT; e++) begin
        int lo, mode, hits;
        logic v;
        lo   = elem_lo(j, e);
        mode = field(w, lo + EW - 2, 2);
        hits = 0;
        for (int k = 0; k < N_LIT; k++)
          hits += int'(lit_val(field(w, lo + (N_LIT - 1 - k) * SW, SW), x, s));
        case (mode)
          0:       v = 1'b0;
          1:       v = (hits == N_LIT);
          2:       v = (hits > 0);
          default: v = lit_val(field(w, lo + (N_LIT - 1) * SW, SW), x, s);
        endcase
        n_true += int'(v);
      end
      if (field(w, j * OW + OW - 1, 1) == 1) r[j] = (n_true > 0);
      else                                   r[j] = (n_true == N_PT);
    end
    return r;
  endfunction

  word_t           m_shadow, m_active;
  int              m_n;
  logic            m_par, m_valid, m_err, m_ack, m_nack, m_upset;
  logic [N_ST-1:0] m_state;

  // Model: a commit is accepted only when exactly CW bits were shifted since
  // the last commit/reset and the shadow parity matches.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_shadow = '0; m_active = '0; m_n = 0; m_par = 1'b0; m_valid = 1'b0;
      m_err = 1'b0; m_ack = 1'b0; m_nack = 1'b0; m_upset = 1'b0; m_state = '0;
    end else begin
      logic par_ok, gate, acc;
      par_ok = ((^m_active) == m_par);
`ifdef SOPFSM_CFG_TMR_EN
      gate = m_valid && par_ok;
`else
      gate = m_valid && par_ok && !m_err;
`endif
      if (step && gate) m_state = model_ns(m_active, in_i, m_state);
      acc     = cfg_commit && (m_n == CW) && ((^m_shadow) == cfg_par);
      m_err   = acc ? 1'b0 : (m_err || !par_ok || m_upset);
      m_upset = 1'b0;
      m_ack   = cfg_commit && acc;
      m_nack  = cfg_commit && !acc;
      if (acc) begin
        m_active = m_shadow;
        m_par    = cfg_par;
        m_valid  = 1'b1;
      end
      if (cfg_commit) m_n = 0;
      else if (cfg_shift) begin
        if (m_n < CW) m_shadow = {m_shadow[CW-2:0], cfg_din};
        m_n++;
      end
    end
  end

  // Compare process: all outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("state_q",   32'(state_q),   32'(m_state));
      check("cfg_valid", 32'(cfg_valid), 32'(m_valid));
      check("cfg_ack",   32'(cfg_ack),   32'(m_ack));
      check("cfg_nack",  32'(cfg_nack),  32'(m_nack));
      check("cfg_err",   32'(cfg_err),   32'(m_err));
    end
  end

  // ---------------- stimulus tasks (drive, then wait one cycle) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic shift_bits(input word_t w, input int n);
    word_t t;
    for (int i = 0; i < n; i++) begin
      t         = w >> (CW - 1 - (i % CW));
      cfg_shift = 1'b1;
      cfg_din   = t[0];
      @(negedge clk);
    end
    cfg_shift = 1'b0;
  endtask

  task automatic commit(input logic par, input logic with_step, input logic with_shift);
    cfg_commit = 1'b1;
    cfg_par    = par;
    step       = with_step;
    cfg_shift  = with_shift;
    cfg_din    = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    step       = 1'b0;
    cfg_shift  = 1'b0;
  endtask

  task automatic do_step(input logic [N_IN-1:0] x);
    in_i = x;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t cfg_a, cfg_b, flipped;
    logic  par_a, par_b;

    // cfg_a: bit0 = ~in0 & ~in1 & in2 (OR-combined with two const-0 elements),
    // bit1 all const 0.
    cfg_a = '0;
    cfg_a = put(cfg_a, 0 * OW + OW - 1, 1);
    cfg_a = set_elem(cfg_a, 0, 0, 1, 5, 6, 2, 10);
    par_a = ^cfg_a;

    // cfg_b: bit1 = state_q[0] passthrough;
    // bit0 = (in0 | in1 | ~state_q[0]) AND-combined with two const-1 passthroughs.
    cfg_b = '0;
    cfg_b = put(cfg_b, 1 * OW + OW - 1, 1);
    cfg_b = set_elem(cfg_b, 1, 0, 3, 3, 0, 0, 0);
    cfg_b = set_elem(cfg_b, 0, 0, 2, 0, 1, 8, 11);
    cfg_b = set_elem(cfg_b, 0, 1, 3, 10, 0, 0, 0);
    cfg_b = set_elem(cfg_b, 0, 2, 3, 10, 0, 0, 0);
    par_b = ^cfg_b;

    // Reset state.
    repeat (2) tick();
    check("rst_state", 32'(state_q), 32'd0);
    check("rst_valid", 32'(cfg_valid), 32'd0);
    check("rst_err",   32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Short load is rejected and stepping stays disabled.
    shift_bits(cfg_a, CW - 1);
    commit(par_a, 1'b0, 1'b0);
    check("short_nack",  32'(cfg_nack),  32'd1);
    check("short_valid", 32'(cfg_valid), 32'd0);
    do_step(3'b100);
    check("short_step", 32'(state_q), 32'd0);

    // Full load with wrong parity, then overlong load with right parity.
    shift_bits(cfg_a, CW);
    commit(~par_a, 1'b0, 1'b0);
    check("badpar_nack", 32'(cfg_nack), 32'd1);
    shift_bits(cfg_a, CW + 1);
    commit(par_a, 1'b0, 1'b0);
    check("ovf_nack", 32'(cfg_nack), 32'd1);

    // Good load of cfg_a.
    shift_bits(cfg_a, CW);
    commit(par_a, 1'b0, 1'b0);
    check("a_ack",   32'(cfg_ack),   32'd1);
    check("a_valid", 32'(cfg_valid), 32'd1);
    do_step(3'b100);
    check("a_step1", 32'(state_q), 32'd1);
    do_step(3'b101);
    check("a_step2", 32'(state_q), 32'd0);
    do_step(3'b011);
    check("a_step3", 32'(state_q), 32'd0);

    // Load cfg_b; commit together with step (old config) and a dropped shift.
    shift_bits(cfg_b, CW);
    in_i = 3'b100;
    commit(par_b, 1'b1, 1'b1);
    check("b_ack",       32'(cfg_ack), 32'd1);
    check("b_step_old",  32'(state_q), 32'd1);
    do_step(3'b000);
    check("b_step1", 32'(state_q), 32'd2);
    do_step(3'b000);
    check("b_step2", 32'(state_q), 32'd1);
    do_step(3'b011);
    check("b_step3", 32'(state_q), 32'd3);

    // Upset in the active configuration.
    flipped    = cfg_b;
    flipped[7] = ~flipped[7];
`ifdef SOPFSM_CFG_TMR_EN
    force dut.act_q[1] = flipped;
    m_upset = 1'b1;
    do_step(3'b000);
    check("tmr_err",  32'(cfg_err), 32'd1);
    check("tmr_step", 32'(state_q), 32'd2);
    release dut.act_q[1];
    tick();
    check("tmr_scrub", (dut.act_q[1] == cfg_b) ? 32'd1 : 32'd0, 32'd1);
`else
    force dut.active_q = flipped;
    m_active = flipped;
    do_step(3'b000);
    check("upset_err",   32'(cfg_err), 32'd1);
    check("upset_step1", 32'(state_q), 32'd3);
    do_step(3'b000);
    check("upset_step2", 32'(state_q), 32'd3);
    release dut.active_q;
    tick();
`endif
    shift_bits(cfg_b, CW);
    commit(par_b, 1'b0, 1'b0);
    check("recommit_ack", 32'(cfg_ack), 32'd1);
    check("recommit_err", 32'(cfg_err), 32'd0);
    do_step(3'b000);
    tick();

    // Reset in the middle of a load discards count and shadow.
    shift_bits(cfg_a, 50);
    rst_n = 1'b0;
    tick();
    check("mid_rst_state", 32'(state_q),   32'd0);
    check("mid_rst_valid", 32'(cfg_valid), 32'd0);
    check("mid_rst_ack",   32'(cfg_ack),   32'd0);
    check("mid_rst_nack",  32'(cfg_nack),  32'd0);
    check("mid_rst_err",   32'(cfg_err),   32'd0);
    rst_n = 1'b1;
    tick();
    shift_bits(cfg_a, CW);
    commit(par_a, 1'b0, 1'b0);
    check("post_rst_ack", 32'(cfg_ack), 32'd1);
    do_step(3'b100);
    check("post_rst_step", 32'(state_q), 32'd1);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sop_fsm_fabric.md
# sop_fsm_fabric

Parametrised, runtime-reconfigurable next-state fabric for the fault-tolerant satellite FSM. It generalises the fixed literal-mux / AND-OR product-element array to N_ST state bits, N_PT product elements per bit and N_LIT literals per element. State bits are fed back into the literal pool and registered in a state register. Configuration loads serially into a shadow register, is parity-checked on commit, and the active copy is monitored every cycle so upsets are detected.

## Interface
- N_IN, 3, external input count
- N_ST, 2, state bits (one next-state function per bit)
- N_PT, 3, product elements per state bit
- N_LIT, 4, literal selectors per product element
- Derived: P = 2*(N_IN+N_ST)+1 pool size; SW = clog2(P); OW = N_PT*(N_LIT*SW+2)+1; CW = N_ST*OW (defaults: SW=4, OW=55, CW=110)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_i  in  N_IN  external inputs (I1..I3 at defaults)
- step  in  1  advance state register this cycle
- cfg_shift  in  1  shift cfg_din into shadow register
- cfg_din  in  1  serial configuration bit, MSB of word first
- cfg_commit  in  1  request shadow→active transfer
- cfg_par  in  1  expected even parity (XOR) of the shadow word
- state_q  out  N_ST  current state
- cfg_valid  out  1  an active configuration has been committed
- cfg_ack  out  1  one-cycle pulse, commit accepted
- cfg_nack  out  1  one-cycle pulse, commit rejected
- cfg_err  out  1  sticky active-configuration fault flag

## Operation
- Literal codes: 0..N_IN-1 in_i[k]; N_IN..N_IN+N_ST-1 state_q[k]; next N_IN+N_ST codes the complements in the same order; 2*(N_IN+N_ST) constant 1; codes above constant 0.
- Element mode (2 bits): 00 constant 0, 01 AND of literals, 10 OR of literals, 11 literal 0 passthrough.
- Per state bit j: combine bit (0 AND, 1 OR) over its N_PT elements gives ns[j].
- Word layout: bit j slice [(j+1)*OW-1 : j*OW]; slice top bit = combine; then element 0..N_PT-1 from high to low; within element: mode (2 bits) then lit0..lit(N_LIT-1) selectors, high to low.
- Loader FSM: IDLE (cnt=0) → SHIFT on cfg_shift; cnt counts bits; at cnt=CW → FULL; cfg_shift in FULL → OVF (cnt frozen, further bits ignored). Shadow shifts {shadow[CW-2:0], cfg_din}.
- cfg_commit in any state: accept iff state FULL and ^shadow == cfg_par → active ← shadow, stored parity ← cfg_par, cfg_valid ← 1, cfg_err ← 0, cfg_ack pulse; else cfg_nack pulse, active unchanged. Either way loader returns to IDLE, cnt=0; shadow retains contents.
- Commit with cfg_shift same cycle: commit wins, bit dropped.
- Integrity: every cycle ^active compared to stored parity; mismatch sets cfg_err (sticky until accepted commit or reset).
- state_q ← ns on step when cfg_valid=1 and cfg_err=0; otherwise held.

## Timing
- Reset: state_q=0, active=0, shadow=0, stored parity=0, cfg_valid=0, cfg_ack=0, cfg_nack=0, cfg_err=0, loader IDLE.
- ns is combinational from in_i, state_q, active; state_q updates on the step edge (1-cycle latency).
- cfg_ack/cfg_nack assert the cycle after the cfg_commit edge, coincident with new active contents.
- step and accepted commit in same cycle: step uses the old active configuration.
- cfg_err asserts the cycle after the corrupting edge; step in that cycle is already blocked.
- Reset mid-load discards shadow and count.

## Configuration
- SOPFSM_CFG_TMR_EN defined: active held in three copies; logic uses bitwise majority; every cycle all copies rewritten with the voted word (scrub); cfg_err sets when any copy disagrees or voted parity mismatches; step blocked only on voted parity mismatch.
- Undefined: single active copy, parity detection only, no correction.

## Test plan
- Program bit0 = ~in0&~in1&in2 (element0 mode 01, lits 5,6,2,10; other elements mode 00; combine 1), bit1 mode-00 everywhere, correct cfg_par → cfg_ack; in_i=3'b100, step → state_q=2'b01; in_i=3'b101, step → 2'b00.
- Shift 109 bits then commit → cfg_nack, cfg_valid stays 0, step leaves state_q=0.
- Shift 110 bits with inverted cfg_par → cfg_nack; shift 111 bits with correct parity → cfg_nack.
- After valid commit, force one active bit flipped → cfg_err=1 next cycle, step ignored; recommit → cfg_err=0.
- TMR_EN: flip one copy bit → cfg_err=1, state_q still steps correctly, copy scrubbed next cycle.
- rst_n low mid-shift (cnt=50) → all outputs zero; fresh 110-bit load then accepted.
